// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction prefetch buffer.
package fetch_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam logic [1:0] CONSUME_NONE = 2'd0;
  localparam logic [1:0] CONSUME_ONE  = 2'd1;
  localparam logic [1:0] CONSUME_TWO  = 2'd2;

  // Bytes actually retired: a request larger than what is presented is clipped.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular byte buffer with single-byte push, 0..2-byte pop and synchronous flush.
module fetch_byte_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic [1:0]                   i_pop,
  input  logic                         i_flush,
  output logic [DATA_W-1:0]            o_rd0,
  output logic [DATA_W-1:0]            o_rd1,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_rd_ptr1;

  // Storage carries no reset; reads are gated by the count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
  assign o_rd0     = (r_count != '0)          ? r_mem[r_rd_ptr]  : '0;
  assign o_rd1     = (r_count >= CNT_W'(2))   ? r_mem[w_rd_ptr1] : '0;
  assign o_count   = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential ROM prefetcher feeding up to two bytes per cycle to decode, with redirect.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      ADDR_W     = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] opcode1,
  output logic [DATA_W-1:0] opcode2,
  output logic [1:0]        out_count,
  output logic [ADDR_W-1:0] head_pc,
  input  logic [1:0]        consume,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              consume_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_head_pc;
  logic              r_inflight;
  logic              r_consume_err;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [OCC_W-1:0]  w_occupancy;
  logic [1:0]        w_out_count;
  logic [1:0]        w_pop;
  logic              w_push;
  logic              w_req;
  logic              w_over;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;

  // Slots already promised to an in-flight read count as occupied.
  assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(r_inflight);
  assign w_req       = reset & ~redirect & (w_occupancy < OCC_W'(DEPTH));

  assign w_out_count = (w_fifo_count >= CNT_W'(2)) ? CONSUME_TWO : 2'(w_fifo_count);
  assign w_over      = ~redirect & (consume > w_out_count);
  assign w_pop       = redirect ? CONSUME_NONE : clamp_pop(consume, w_out_count);
  assign w_push      = r_inflight & ~redirect;

  fetch_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data (rom_data),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_rd0       (w_rd0),
    .o_rd1       (w_rd1),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_ADDR;
      r_head_pc     <= RESET_ADDR;
      r_inflight    <= 1'b0;
      r_consume_err <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (redirect) begin
        r_fetch_pc <= redirect_addr;
        r_head_pc  <= redirect_addr;
      end else begin
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        end
        r_head_pc <= r_head_pc + ADDR_W'(w_pop);
      end
      if (w_over) begin
        r_consume_err <= 1'b1;
      end
    end
  end

  assign rom_req     = w_req;
  assign rom_address = r_fetch_pc;
  assign opcode1     = w_rd0;
  assign opcode2     = w_rd1;
  assign out_count   = w_out_count;
  assign head_pc     = r_head_pc;
  assign consume_err = r_consume_err;

endmodule
